// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings, stage record and helpers for the hazard controller
package hazard_pkg;

  localparam logic [2:0] FWD_GRF        = 3'd0;
  localparam logic [2:0] FWD_PC8_EX     = 3'd1;
  localparam logic [2:0] FWD_ALU_MEM    = 3'd2;
  localparam logic [2:0] FWD_PC8_MEM    = 3'd3;
  localparam logic [2:0] FWD_MDM_RD_MEM = 3'd4;
  localparam logic [2:0] FWD_WD_WB      = 3'd5;
  localparam logic [2:0] FWD_PC8_WB     = 3'd6;

  localparam logic [1:0] ALU_FWD_REG     = 2'd0;
  localparam logic [1:0] ALU_FWD_ALU_MEM = 2'd1;
  localparam logic [1:0] ALU_FWD_PC8_MEM = 2'd2;
  localparam logic [1:0] ALU_FWD_WD_WB   = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {KIND_ALU = 2'd0, KIND_LOAD = 2'd1, KIND_LINK = 2'd2} kind_e;
  typedef enum logic [1:0] {MD_NONE = 2'd0, MD_MULT = 2'd1, MD_DIV = 2'd2} md_start_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic [1:0] tnew;
    kind_e      kind;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '{valid: 1'b0, dst: 5'd0, tnew: 2'd0, kind: KIND_ALU};

  function automatic stage_t advance(input stage_t s);
    stage_t r;
    r = s;
    r.tnew = (s.tnew == 2'd0) ? 2'd0 : s.tnew - 2'd1;
    return r;
  endfunction

  // EX operands only see MEM/WB, so the wider ID code folds onto the 2-bit mux
  function automatic logic [1:0] alu_sel(input logic [2:0] code);
    case (code)
      FWD_ALU_MEM:           return ALU_FWD_ALU_MEM;
      FWD_PC8_MEM:           return ALU_FWD_PC8_MEM;
      FWD_WD_WB, FWD_PC8_WB: return ALU_FWD_WD_WB;
      default:               return ALU_FWD_REG;
    endcase
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage decode fields in, forward selects and stall out
interface hazard_ctrl_if;
  logic [4:0] rs_ID, rt_ID, dst_ID;
  logic [1:0] tuse_rs_ID, tuse_rt_ID, tnew_ID, kind_ID, md_start_ID;
  logic       md_use_ID;
  logic       stall, md_busy;
  logic [2:0] CMPAfor, CMPBfor, Rafor;
  logic [1:0] ALUAfor, ALUBfor;

  modport master (
    output rs_ID, rt_ID, tuse_rs_ID, tuse_rt_ID, dst_ID, tnew_ID, kind_ID, md_start_ID, md_use_ID,
    input  stall, md_busy, CMPAfor, CMPBfor, Rafor, ALUAfor, ALUBfor
  );

  modport slave (
    input  rs_ID, rt_ID, tuse_rs_ID, tuse_rt_ID, dst_ID, tnew_ID, kind_ID, md_start_ID, md_use_ID,
    output stall, md_busy, CMPAfor, CMPBfor, Rafor, ALUAfor, ALUBfor
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - youngest-match forward select and stall request for one operand
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] operand,
  input  logic [1:0] tuse,
  input  stage_t     ex,
  input  stage_t     mem,
  input  stage_t     wb,
  output logic [2:0] sel,
  output logic       stall_req
);

  function automatic logic hit(input stage_t s, input logic [4:0] r);
    return s.valid && (s.dst != 5'd0) && (s.dst == r);
  endfunction

  logic       found;
  logic [1:0] tnew;

  always_comb begin
    sel   = FWD_GRF;
    found = 1'b0;
    tnew  = 2'd0;
    if (hit(ex, operand)) begin
      found = 1'b1;
      tnew  = ex.tnew;
      if (ex.tnew == 2'd0 && ex.kind == KIND_LINK) sel = FWD_PC8_EX;
    end else if (hit(mem, operand)) begin
      found = 1'b1;
      tnew  = mem.tnew;
      if (mem.tnew == 2'd0) begin
        if (mem.kind == KIND_ALU)       sel = FWD_ALU_MEM;
        else if (mem.kind == KIND_LINK) sel = FWD_PC8_MEM;
      end
    end else if (hit(wb, operand)) begin
      found = 1'b1;
      tnew  = wb.tnew;
      if (wb.tnew == 2'd0) sel = (wb.kind == KIND_LINK) ? FWD_PC8_WB : FWD_WD_WB;
    end
    stall_req = found && (tuse != TUSE_NONE) && (tnew > tuse);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/forwarding controller with MDU busy counter
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  stage_t           ex_q, mem_q, wb_q;
  logic [4:0]       ex_rs_q, ex_rt_q;
  md_start_e        ex_md_q;
  logic [CNT_W-1:0] md_cnt_q;

  logic [2:0] id_req;
  logic [1:0] alu_req_unused;
  logic [2:0] alu_a_code, alu_b_code;
  logic       md_busy, md_stall, stall;

  hazard_fwd_sel u_cmpa (.operand(bus.rs_ID), .tuse(bus.tuse_rs_ID), .ex(ex_q), .mem(mem_q),
                         .wb(wb_q), .sel(bus.CMPAfor), .stall_req(id_req[0]));
  hazard_fwd_sel u_cmpb (.operand(bus.rt_ID), .tuse(bus.tuse_rt_ID), .ex(ex_q), .mem(mem_q),
                         .wb(wb_q), .sel(bus.CMPBfor), .stall_req(id_req[1]));
  hazard_fwd_sel u_ra   (.operand(bus.rs_ID), .tuse(bus.tuse_rs_ID), .ex(ex_q), .mem(mem_q),
                         .wb(wb_q), .sel(bus.Rafor), .stall_req(id_req[2]));

  // EX consumers look only downstream; the instruction itself is never a producer for them
  hazard_fwd_sel u_alua (.operand(ex_rs_q), .tuse(TUSE_NONE), .ex(STAGE_EMPTY), .mem(mem_q),
                         .wb(wb_q), .sel(alu_a_code), .stall_req(alu_req_unused[0]));
  hazard_fwd_sel u_alub (.operand(ex_rt_q), .tuse(TUSE_NONE), .ex(STAGE_EMPTY), .mem(mem_q),
                         .wb(wb_q), .sel(alu_b_code), .stall_req(alu_req_unused[1]));

  assign md_busy  = (md_cnt_q != '0);
  assign md_stall = bus.md_use_ID && (md_busy || (ex_q.valid && ex_md_q != MD_NONE));
  assign stall    = (|id_req) || md_stall;

  assign bus.stall   = stall;
  assign bus.md_busy = md_busy;
  assign bus.ALUAfor = alu_sel(alu_a_code);
  assign bus.ALUBfor = alu_sel(alu_b_code);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q     <= STAGE_EMPTY;
      mem_q    <= STAGE_EMPTY;
      wb_q     <= STAGE_EMPTY;
      ex_rs_q  <= 5'd0;
      ex_rt_q  <= 5'd0;
      ex_md_q  <= MD_NONE;
      md_cnt_q <= '0;
    end else begin
      mem_q <= advance(ex_q);
      wb_q  <= advance(mem_q);
      if (stall) begin
        ex_q    <= STAGE_EMPTY;
        ex_rs_q <= 5'd0;
        ex_rt_q <= 5'd0;
        ex_md_q <= MD_NONE;
      end else begin
        ex_q    <= '{valid: 1'b1, dst: bus.dst_ID, tnew: bus.tnew_ID, kind: kind_e'(bus.kind_ID)};
        ex_rs_q <= bus.rs_ID;
        ex_rt_q <= bus.rt_ID;
        ex_md_q <= md_start_e'(bus.md_start_ID);
      end
      // the counter keeps running through stalls; a new MD op reloads it as it leaves EX
      if (ex_q.valid && ex_md_q != MD_NONE)
        md_cnt_q <= (ex_md_q == MD_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      else if (md_busy)
        md_cnt_q <= md_cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and forwarding controller for the five-stage MIPS pipeline.
- Tracks destination register, Tnew and result kind of every in-flight instruction in the EX, MEM and WB stages.
- From that state it generates:
  - the ID-stage forward selects (CMPA, CMPB, jr target);
  - the EX-stage ALU operand selects;
  - the global stall.
- Owns the multiply/divide busy counter, so that MD-class instructions are held in ID while the MDU is busy.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu leaves EX.
- DIV_CYCLES, 10, busy cycles after div/divu leaves EX.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-low; clears all tracking state.
- rs_ID  input  5  rs field of the instruction in ID.
- rt_ID  input  5  rt field of the instruction in ID.
- tuse_rs_ID  input  2  cycles until rs is consumed (0 = ID compare/jr, 1 = EX, 3 = unused).
- tuse_rt_ID  input  2  same encoding, for rt.
- dst_ID  input  5  destination register of the ID instruction (0 = none).
- tnew_ID  input  2  cycles after entering EX until the result exists: link 0, ALU/mf 1, load 2.
- kind_ID  input  2  result kind: 0 ALU, 1 load, 2 link.
- md_start_ID  input  2  0 none, 1 mult/multu, 2 div/divu.
- md_use_ID  input  1  instruction is mult/div/mfhi/mflo/mthi/mtlo.
- stall  output  1  freeze PC and IF/ID; insert a bubble into ID/EX.
- CMPAfor  output  3  compare operand A select.
- CMPBfor  output  3  compare operand B select.
- Rafor  output  3  jr/jalr target select.
- ALUAfor  output  2  EX operand A select: 0 ID/EX reg, 1 ALUResult_MEM, 2 PC8_MEM, 3 WD_WB.
- ALUBfor  output  2  EX operand B select, same encoding as ALUAfor.
- md_busy  output  1  MDU counter is non-zero.

Behaviour:
- 3-bit forward-select encoding (package constants):
  - 0 GRF;
  - 1 PC8_EX;
  - 2 ALUResult_MEM;
  - 3 PC8_MEM;
  - 4 MDM_RD_MEM (reserved, never driven);
  - 5 WD_WB;
  - 6 PC8_WB.
- Per-stage state record for EX, MEM and WB: dst, tnew, kind, valid. EX additionally holds rs and rt.
- Register update on each rising clk:
  - WB <= MEM.
  - MEM <= EX, with tnew decremented and saturating at 0.
  - EX <= ID fields; a bubble (valid=0, dst=0) is loaded instead when stall=1.
  - tnew is decremented on every stage advance, saturating at 0.
- Forwarding and stall outputs are purely combinational from state and ID inputs; there is no added latency.
- A stage matches an operand when valid, dst != 0 and dst == operand.
- Matching priority is EX > MEM > WB; only the youngest match counts.
- Source chosen for a youngest match with tnew == 0:
  - EX: link → 1.
  - MEM: ALU → 2; link → 3.
  - WB: ALU or load → 5; link → 6.
- A match with tnew > 0 yields select 0 and may raise stall.
- Stall conditions, for each operand with tuse != 3:
  - stall if the youngest match has tnew > tuse;
  - stall if md_use_ID and (md_busy or EX holds an md_start);
  - stall is the OR of all conditions.
- While stall=1, CMPAfor, CMPBfor and Rafor are still driven, but their values are don't-care to the datapath.
- ALUAfor/ALUBfor use the EX rs/rt against the MEM and WB records:
  - MEM match with tnew 0 → 1 (ALU) or 2 (link);
  - otherwise a WB match → 3;
  - otherwise 0.
- MDU counter:
  - When an EX record with md_start advances to MEM, load MULT_CYCLES or DIV_CYCLES.
  - Otherwise decrement each cycle while non-zero.
  - md_busy = (count != 0).
  - Back-to-back mult issue is blocked by the md_use stall.
- Register 0 never matches and never stalls.
- Reset (active-low, asynchronous): all stages are bubbles, counter is 0, stall=0, all selects 0, md_busy=0. Reset mid-stall drops the stall immediately.
- Simultaneous stall and MDU countdown: the counter keeps counting.

Decomposition:
- Shared package hazard_pkg: forward-select constants, kind constants, md_start codes, stage-record struct.
- One sub-module, hazard_fwd_sel: combinational youngest-match / select / stall-request per operand, instantiated 3 times in ID and 2 times in EX.

Test Plan:
- addu $1,$2,$3 then beq $1,$0: cycle 1 stall=1 (EX tnew 1 > tuse 0); cycle 2 stall=0, CMPAfor=2.
- lw $4,0($0) then addu $5,$4,$4: one stall cycle; the following cycle ALUAfor=3 and ALUBfor=3.
- jal then jr $31 immediately: stall=0, Rafor=1. With one nop between: Rafor=3. With two nops: Rafor=6.
- div then mflo: stall held high for 11 cycles, with md_busy high for 10 of them; mflo issues the cycle md_busy falls.
- addu $0,$1,$2 then beq $0,$0: stall=0, CMPAfor=0, CMPBfor=0.
- reset low during a lw-use stall: stall, md_busy and all selects go to 0 asynchronously; after release with a fresh stream, no spurious forwarding.
